dsa_simd_scheduler: RTL and testbench
=====================================

// Module: dsa_simd_scheduler
// PURPOSE
//  Job sequencer for dsa_datapath_simd (N-lane bilinear interpolator). Walks a dst_w x dst_h output
//  image in raster order, N pixels per group. Per group: fetches the 4 source neighbours per lane
//  over a single-outstanding read port, loads lane operands, pulses dp_start and waits for dp_done.
//  Then writes the lane results to the output buffer. Sits between the host config regs, pixel memory and the datapath.
// PARAMETERS
//  N       4   lane count; must match the datapath instance
//  DIM_W   10  width of image dimensions (max 1023)
//  ADDR_W  20  pixel address width (byte address, one pixel per address)
// PORTS
//  clk        in   1        clock
//  rst        in   1        synchronous reset, active-high
//  job_start  in   1        1-cycle pulse; samples all cfg_* when IDLE
//  cfg_src_w  in   DIM_W    source width;  cfg_src_h in DIM_W source height
//  cfg_dst_w  in   DIM_W    output width;  cfg_dst_h in DIM_W output height
//  cfg_step_x in   16       Q8.8 source step per output column
//  cfg_step_y in   16       Q8.8 source step per output row
//  cfg_src_base/cfg_dst_base in ADDR_W  base addresses of source / output images
//  busy       out  1        high from accepted job_start until job_done
//  job_done   out  1        1-cycle pulse after last write completes
//  rd_req     out  1        1-cycle read request;  rd_addr out ADDR_W
//  rd_valid   in   1        read data valid (any latency >=1);  rd_data in 8
//  dp_start   out  1        1-cycle start to datapath
//  dp_done    in   1        datapath done
//  dp_p00/p01/p10/p11 out [7:0][0:N-1]  lane neighbour pixels
//  dp_a/dp_b  out  [15:0][0:N-1]        Q8.8 horizontal / vertical fraction, value 0..255
//  dp_pixel   in   [7:0][0:N-1]         lane results
//  wr_en      out  1        write request, held until wr_ready;  wr_addr out ADDR_W;  wr_data out 8
//  wr_ready   in   1        write accepted when wr_en & wr_ready
// BEHAVIOUR
//  Reset: all outputs 0, all lane operand regs 0, FSM -> IDLE; reset mid-job aborts with no job_done.
//  FSM: IDLE -> ROW (compute sy) -> FETCH -> COMPUTE -> WAIT_DP -> WRITE -> NEXT -> (FETCH|ROW|DONE) -> IDLE.
//  IDLE: job_start ignored unless IDLE; cfg_* latched on accept; busy=1 next cycle.
//   dst_w==0 or dst_h==0: job_done pulses 2 cycles after job_start, no reads/writes.
//  Coordinates (accumulators, no multipliers): sx=x*step_x, sy=y*step_y, DIM_W+8 bits, no wrap.
//   ix=sx>>8, a={8'h00,sx[7:0]}; iy=sy>>8, b={8'h00,sy[7:0]}.
//   ix clamped to src_w-1, iy to src_h-1; ix1=min(ix+1,src_w-1), iy1=min(iy+1,src_h-1).
//   addr = src_base + row*src_w + col; row*src_w kept as running row-base, updated in ROW.
//  FETCH: active lanes in ascending order, per lane p00(iy,ix) p01(iy,ix1) p10(iy1,ix) p11(iy1,ix1).
//   One rd_req pulse per read; next rd_req no earlier than the cycle after rd_valid. Data in issue order.
//   rd_valid while no read outstanding is ignored.
//  Partial group: lanes with x>=dst_w are inactive; no reads, operands forced 0, no write.
//  COMPUTE: dp_start high exactly 1 cycle; operands stable from that cycle until dp_done.
//  WAIT_DP: dp_start->dp_done latency is arbitrary. dp_pixel is captured on the dp_done cycle.
//  WRITE: active lanes ascending; wr_addr=dst_base+y*dst_w+x; wr_en/addr/data stable until wr_ready;
//   back-to-back writes allowed (wr_en stays high, addr advances after each accept).
//  NEXT: x+=N; if x>=dst_w then x=0, y++; if y==dst_h -> DONE. DONE pulses job_done, busy=0 same cycle.
//  Throughput: group latency = 4*active_lanes*read_latency + dp latency + active_lanes writes + 3 cycles.
// TESTING
//  T1 src 2x2 {100,120;140,160}, dst 4x4, step 0x0080: out(0,0)=100, (1,1)=130, (3,3)=160 (clamp), 16 writes.
//  T2 src 2x2 {50,150;100,200}, dst 1x1, step_x 0x0040(start a=0): out=50; via dst 2x1, out(1,0)=75 (a=0.25).
//  T3 dst_w=6, N=4: group 2 issues exactly 8 reads, 2 writes (x=4,5); lanes 2,3 operands 0.
//  T4 rd_valid latency 1 and random 1-5, wr_ready random stalls, dp_done latency 3..10: output identical.
//  T5 rst asserted mid-FETCH: next cycle all outputs 0, busy=0; new job_start runs T1 correctly.
//  T6 dst_h=0: job_done 2 cycles after job_start, zero rd_req/wr_en; job_start while busy ignored.

Source files
------------

// File: rtl/dsa_simd_scheduler.sv
// Job sequencer for an N-lane bilinear datapath: walks the output image in raster order,
// fetches four source neighbours per lane, runs the datapath and writes the lane results.
//
// state     | meaning
// IDLE      | waiting for job_start, cfg latched on accept
// ROW       | advance source row base until it matches iy for this output row
// FETCH     | issue/collect 4 reads per active lane, zero inactive lanes
// COMPUTE   | dp_start high for exactly this cycle
// WAIT_DP   | wait for dp_done, capture lane results
// WRITE     | write active lane results in ascending order
// NEXT      | advance x / y, pick next group, row or finish
// DONE      | pulse job_done, drop busy
module dsa_simd_scheduler #(
  parameter int N      = 4,
  parameter int DIM_W  = 10,
  parameter int ADDR_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    job_start,
  input  logic [DIM_W-1:0]        cfg_src_w,
  input  logic [DIM_W-1:0]        cfg_src_h,
  input  logic [DIM_W-1:0]        cfg_dst_w,
  input  logic [DIM_W-1:0]        cfg_dst_h,
  input  logic [15:0]             cfg_step_x,
  input  logic [15:0]             cfg_step_y,
  input  logic [ADDR_W-1:0]       cfg_src_base,
  input  logic [ADDR_W-1:0]       cfg_dst_base,
  output logic                    busy,
  output logic                    job_done,
  output logic                    rd_req,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic                    rd_valid,
  input  logic [7:0]              rd_data,
  output logic                    dp_start,
  input  logic                    dp_done,
  output logic [0:N-1][7:0]       dp_p00,
  output logic [0:N-1][7:0]       dp_p01,
  output logic [0:N-1][7:0]       dp_p10,
  output logic [0:N-1][7:0]       dp_p11,
  output logic [0:N-1][15:0]      dp_a,
  output logic [0:N-1][15:0]      dp_b,
  input  logic [0:N-1][7:0]       dp_pixel,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [7:0]              wr_data,
  input  logic                    wr_ready
);
  localparam int SW = DIM_W + 8;
  localparam int LW = (N > 1) ? $clog2(N) : 1;
  localparam int XW = DIM_W + 2;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ROW     = 3'd1;
  localparam logic [2:0] S_FETCH   = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_WAIT_DP = 3'd4;
  localparam logic [2:0] S_WRITE   = 3'd5;
  localparam logic [2:0] S_NEXT    = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  logic [2:0]             state;
  logic [DIM_W-1:0]       c_src_w, c_src_h, c_dst_w, c_dst_h;
  logic [15:0]            c_step_x, c_step_y;
  logic [DIM_W-1:0]       x, y, row_iy;
  logic [SW-1:0]          sx, sy;
  logic [ADDR_W-1:0]      row_base, row1_base, out_addr;
  logic [LW-1:0]          lane, wlane;
  logic [1:0]             rd_sel;
  logic                   rd_pend;
  logic [0:N-1][7:0]      res;

  logic [DIM_W-1:0]  w_lim, h_lim, ix_raw, iy_raw, ix, ix1, iy_tgt, rd_col;
  logic [SW:0]       sx_inc, sy_inc;
  logic [SW-1:0]     sx_nxt, sy_nxt;
  logic [ADDR_W-1:0] rd_addr_nxt;
  logic [LW-1:0]     wl_nxt;
  logic              lane_act, wl_act, lane_last, wl_last, grp_end, row_last;

  assign w_lim  = (c_src_w == '0) ? '0 : c_src_w - DIM_W'(1);
  assign h_lim  = (c_src_h == '0) ? '0 : c_src_h - DIM_W'(1);
  assign ix_raw = sx[SW-1:8];
  assign iy_raw = sy[SW-1:8];
  assign ix     = (ix_raw > w_lim) ? w_lim : ix_raw;
  assign ix1    = (ix < w_lim) ? ix + DIM_W'(1) : w_lim;
  assign iy_tgt = (iy_raw > h_lim) ? h_lim : iy_raw;

  // Accumulators saturate rather than wrap; the clamp then pins them to the last column/row.
  assign sx_inc = {1'b0, sx} + (SW+1)'(c_step_x);
  assign sy_inc = {1'b0, sy} + (SW+1)'(c_step_y);
  assign sx_nxt = sx_inc[SW] ? '1 : sx_inc[SW-1:0];
  assign sy_nxt = sy_inc[SW] ? '1 : sy_inc[SW-1:0];

  assign rd_col      = rd_sel[0] ? ix1 : ix;
  assign rd_addr_nxt = (rd_sel[1] ? row1_base : row_base) + ADDR_W'(rd_col);

  assign wl_nxt    = wlane + LW'(1);
  assign lane_act  = (XW'(x) + XW'(lane)) < XW'(c_dst_w);
  assign wl_act    = (XW'(x) + XW'(wlane) + XW'(1)) < XW'(c_dst_w);
  assign lane_last = (lane == LW'(N-1));
  assign wl_last   = (wlane == LW'(N-1));
  assign grp_end   = (XW'(x) + XW'(N)) >= XW'(c_dst_w);
  assign row_last  = (XW'(y) + XW'(1)) == XW'(c_dst_h);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      c_src_w <= '0; c_src_h <= '0; c_dst_w <= '0; c_dst_h <= '0;
      c_step_x <= '0; c_step_y <= '0;
      x <= '0; y <= '0; row_iy <= '0; sx <= '0; sy <= '0;
      row_base <= '0; row1_base <= '0; out_addr <= '0;
      lane <= '0; wlane <= '0; rd_sel <= '0; rd_pend <= 1'b0; res <= '0;
      busy <= 1'b0; job_done <= 1'b0; rd_req <= 1'b0; rd_addr <= '0;
      dp_start <= 1'b0; dp_p00 <= '0; dp_p01 <= '0; dp_p10 <= '0; dp_p11 <= '0;
      dp_a <= '0; dp_b <= '0; wr_en <= 1'b0; wr_addr <= '0; wr_data <= '0;
    end else begin
      rd_req   <= 1'b0;
      job_done <= 1'b0;
      case (state)
        S_IDLE: if (job_start) begin
          c_src_w <= cfg_src_w; c_src_h <= cfg_src_h;
          c_dst_w <= cfg_dst_w; c_dst_h <= cfg_dst_h;
          c_step_x <= cfg_step_x; c_step_y <= cfg_step_y;
          row_iy <= '0; row_base <= cfg_src_base; out_addr <= cfg_dst_base;
          x <= '0; y <= '0; sx <= '0; sy <= '0;
          busy <= 1'b1;
          state <= (cfg_dst_w == '0 || cfg_dst_h == '0) ? S_DONE : S_ROW;
        end
        S_ROW: begin
          // Row base walks forward one source row per cycle; iy never decreases.
          if (row_iy < iy_tgt) begin
            row_iy   <= row_iy + DIM_W'(1);
            row_base <= row_base + ADDR_W'(c_src_w);
          end else begin
            row1_base <= (iy_tgt < h_lim) ? row_base + ADDR_W'(c_src_w) : row_base;
            lane   <= '0;
            rd_sel <= '0;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!lane_act) begin
            dp_p00[lane] <= '0; dp_p01[lane] <= '0;
            dp_p10[lane] <= '0; dp_p11[lane] <= '0;
            dp_a[lane] <= '0; dp_b[lane] <= '0;
            if (lane_last) begin
              dp_start <= 1'b1;
              state    <= S_COMPUTE;
            end else begin
              lane <= lane + LW'(1);
            end
          end else if (!rd_pend) begin
            rd_req  <= 1'b1;
            rd_addr <= rd_addr_nxt;
            rd_pend <= 1'b1;
          end else if (rd_valid) begin
            rd_pend <= 1'b0;
            case (rd_sel)
              2'd0:    dp_p00[lane] <= rd_data;
              2'd1:    dp_p01[lane] <= rd_data;
              2'd2:    dp_p10[lane] <= rd_data;
              default: dp_p11[lane] <= rd_data;
            endcase
            if (rd_sel == 2'd3) begin
              dp_a[lane] <= {8'h00, sx[7:0]};
              dp_b[lane] <= {8'h00, sy[7:0]};
              sx     <= sx_nxt;
              rd_sel <= '0;
              if (lane_last) begin
                dp_start <= 1'b1;
                state    <= S_COMPUTE;
              end else begin
                lane <= lane + LW'(1);
              end
            end else begin
              rd_sel <= rd_sel + 2'd1;
            end
          end
        end
        S_COMPUTE: begin
          dp_start <= 1'b0;
          state    <= S_WAIT_DP;
        end
        S_WAIT_DP: if (dp_done) begin
          res     <= dp_pixel;
          wlane   <= '0;
          wr_en   <= 1'b1;
          wr_addr <= out_addr;
          wr_data <= dp_pixel[0];
          state   <= S_WRITE;
        end
        S_WRITE: if (wr_ready) begin
          out_addr <= out_addr + ADDR_W'(1);
          if (!wl_last && wl_act) begin
            wlane   <= wl_nxt;
            wr_addr <= out_addr + ADDR_W'(1);
            wr_data <= res[wl_nxt];
          end else begin
            wr_en <= 1'b0;
            state <= S_NEXT;
          end
        end
        S_NEXT: begin
          lane   <= '0;
          rd_sel <= '0;
          if (grp_end) begin
            x  <= '0;
            sx <= '0;
            if (row_last) begin
              state <= S_DONE;
            end else begin
              y     <= y + DIM_W'(1);
              sy    <= sy_nxt;
              state <= S_ROW;
            end
          end else begin
            x     <= x + DIM_W'(N);
            state <= S_FETCH;
          end
        end
        default: begin
          job_done <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dsa_simd_scheduler.sv
// Bench for dsa_simd_scheduler: memory, datapath and write-sink responders plus a
// bilinear reference model; table of jobs followed by hand-written corner sequences.
module tb_dsa_simd_scheduler;
  localparam int N = 4, DIM_W = 10, ADDR_W = 20;

  logic clk = 1'b0, rst = 1'b1, job_start = 1'b0;
  logic [DIM_W-1:0] cfg_src_w = '0, cfg_src_h = '0, cfg_dst_w = '0, cfg_dst_h = '0;
  logic [15:0] cfg_step_x = '0, cfg_step_y = '0;
  logic [ADDR_W-1:0] cfg_src_base = '0, cfg_dst_base = '0;
  logic busy, job_done, rd_req, dp_start, wr_en;
  logic [ADDR_W-1:0] rd_addr, wr_addr;
  logic rd_valid = 1'b0, dp_done = 1'b0, wr_ready = 1'b1;
  logic [7:0] rd_data = '0, wr_data;
  logic [0:N-1][7:0] dp_p00, dp_p01, dp_p10, dp_p11;
  logic [0:N-1][7:0] dp_pixel = '0;
  logic [0:N-1][15:0] dp_a, dp_b;

  always #5 clk = ~clk;

  dsa_simd_scheduler #(.N(N), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .job_start(job_start),
    .cfg_src_w(cfg_src_w), .cfg_src_h(cfg_src_h), .cfg_dst_w(cfg_dst_w), .cfg_dst_h(cfg_dst_h),
    .cfg_step_x(cfg_step_x), .cfg_step_y(cfg_step_y),
    .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base),
    .busy(busy), .job_done(job_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .dp_start(dp_start), .dp_done(dp_done),
    .dp_p00(dp_p00), .dp_p01(dp_p01), .dp_p10(dp_p10), .dp_p11(dp_p11),
    .dp_a(dp_a), .dp_b(dp_b), .dp_pixel(dp_pixel),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  typedef struct {
    int src_w, src_h, dst_w, dst_h, step_x, step_y, src_base, dst_base, img, stress;
    int exp_wr, exp_rd;
  } vec_t;
  vec_t vecs [7];

  int n_cmp = 0, n_bad = 0;
  logic [7:0] mem [0:4095];
  logic [7:0] out_mem [0:4095];
  int cur_src_w, cur_src_h, cur_dst_w, cur_step_x, cur_step_y, cur_src_base, cur_dst_base;
  int stress = 0;
  int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, grp_rd = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int bil(int p00, int p01, int p10, int p11, int a, int b);
    int t, bt;
    t  = p00 * (256 - a) + p01 * a;
    bt = p10 * (256 - a) + p11 * a;
    return (t * (256 - b) + bt * b) >> 16;
  endfunction

  function automatic int model_pix(int x, int y);
    int sx, sy, ix, iy, ix1, iy1, r0, r1;
    sx = x * cur_step_x;  sy = y * cur_step_y;
    ix = sx >> 8;         iy = sy >> 8;
    if (ix > cur_src_w - 1) ix = cur_src_w - 1;
    if (iy > cur_src_h - 1) iy = cur_src_h - 1;
    ix1 = (ix + 1 > cur_src_w - 1) ? cur_src_w - 1 : ix + 1;
    iy1 = (iy + 1 > cur_src_h - 1) ? cur_src_h - 1 : iy + 1;
    r0 = cur_src_base + iy * cur_src_w;
    r1 = cur_src_base + iy1 * cur_src_w;
    return bil(int'(mem[r0 + ix]), int'(mem[r0 + ix1]), int'(mem[r1 + ix]), int'(mem[r1 + ix1]),
               sx % 256, sy % 256);
  endfunction

  // Read port: single outstanding, latency 1 or random 1..5, stray rd_valid when idle under stress.
  int rcnt = 0, raddr = 0;
  initial forever begin
    bit vnow;
    @(negedge clk);
    rd_valid = 1'b0;
    vnow = 1'b0;
    if (rst) begin
      rcnt = 0;
    end else begin
      if (rcnt > 0) begin
        rcnt--;
        if (rcnt == 0) begin
          rd_valid = 1'b1;
          rd_data  = mem[raddr];
          vnow = 1'b1;
        end
      end else if (stress != 0 && !rd_req && $urandom_range(0, 3) == 0) begin
        rd_valid = 1'b1;
        rd_data  = 8'hEE;
      end
      if (rd_req) begin
        if (rcnt != 0 || vnow) chk("rd_overlap", 1, 0);
        raddr = int'(rd_addr[11:0]);
        rcnt  = (stress != 0) ? int'($urandom_range(1, 5)) : 1;
        rd_cnt++;
        grp_rd++;
      end
    end
  end

  // Datapath: captures operands on dp_start, answers after a latency with the bilinear result.
  int dcnt = 0;
  logic [0:N-1][7:0] c00, c01, c10, c11;
  logic [0:N-1][15:0] ca, cb;
  logic prev_start = 1'b0;
  initial forever begin
    int x0, act;
    @(negedge clk);
    dp_done = 1'b0;
    if (rst) begin
      dcnt = 0; grp_rd = 0; prev_start = 1'b0;
    end else begin
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          chk("dp_stable", int'({dp_p00 != c00, dp_p01 != c01, dp_p10 != c10, dp_p11 != c11,
                                  dp_a != ca, dp_b != cb}), 0);
          for (int l = 0; l < N; l++)
            dp_pixel[l] = 8'(bil(int'(c00[l]), int'(c01[l]), int'(c10[l]), int'(c11[l]),
                                 int'(ca[l][7:0]), int'(cb[l][7:0])));
          dp_done = 1'b1;
        end
      end
      if (dp_start) begin
        if (prev_start) chk("dp_start_width", 2, 1);
        c00 = dp_p00; c01 = dp_p01; c10 = dp_p10; c11 = dp_p11; ca = dp_a; cb = dp_b;
        x0  = (cur_dst_w > 0) ? wr_cnt % cur_dst_w : 0;
        act = (cur_dst_w - x0 > N) ? N : cur_dst_w - x0;
        chk("grp_reads", grp_rd, 4 * act);
        grp_rd = 0;
        for (int l = act; l < N; l++)
          chk("lane_zero", int'({dp_p00[l], dp_p01[l], dp_p10[l], dp_p11[l]}) | int'(dp_a[l]) | int'(dp_b[l]), 0);
        dcnt = (stress != 0) ? int'($urandom_range(3, 10)) : 1;
      end
      prev_start = dp_start;
    end
  end

  // Write sink: random stalls under stress; checks hold-while-stalled and every accepted pixel.
  logic hold_pend = 1'b0;
  logic [ADDR_W-1:0] hold_addr;
  logic [7:0] hold_data;
  initial forever begin
    @(negedge clk);
    wr_ready = (stress != 0) ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (job_done) done_cnt++;
      if (hold_pend && !wr_en) chk("wr_drop", 1, 0);
      if (wr_en) begin
        if (hold_pend) chk("wr_hold", int'({wr_addr, wr_data}), int'({hold_addr, hold_data}));
        if (wr_ready) begin
          chk("wr_addr", int'(wr_addr), cur_dst_base + wr_cnt);
          if (cur_dst_w > 0)
            chk("wr_data", int'(wr_data), model_pix(wr_cnt % cur_dst_w, wr_cnt / cur_dst_w));
          out_mem[wr_addr[11:0]] = wr_data;
          wr_cnt++;
          hold_pend = 1'b0;
        end else begin
          hold_pend = 1'b1;
          hold_addr = wr_addr;
          hold_data = wr_data;
        end
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  task automatic start_job(input vec_t v);
    cur_src_w = v.src_w; cur_src_h = v.src_h; cur_dst_w = v.dst_w;
    cur_step_x = v.step_x; cur_step_y = v.step_y;
    cur_src_base = v.src_base; cur_dst_base = v.dst_base;
    stress = v.stress;
    for (int i = 0; i < v.src_w * v.src_h; i++) begin
      case (v.img)
        0: mem[v.src_base + i] = (i == 0) ? 8'd100 : (i == 1) ? 8'd120 : (i == 2) ? 8'd140 : 8'd160;
        1: mem[v.src_base + i] = (i == 0) ? 8'd50  : (i == 1) ? 8'd150 : (i == 2) ? 8'd100 : 8'd200;
        default: mem[v.src_base + i] = 8'((i * 37 + 11) & 255);
      endcase
    end
    rd_cnt = 0; wr_cnt = 0; done_cnt = 0; grp_rd = 0;
    cfg_src_w = DIM_W'(v.src_w); cfg_src_h = DIM_W'(v.src_h);
    cfg_dst_w = DIM_W'(v.dst_w); cfg_dst_h = DIM_W'(v.dst_h);
    cfg_step_x = 16'(v.step_x); cfg_step_y = 16'(v.step_y);
    cfg_src_base = ADDR_W'(v.src_base); cfg_dst_base = ADDR_W'(v.dst_base);
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int c;
    c = 0;
    while (done_cnt == 0 && c < 20000) begin
      @(negedge clk);
      c++;
    end
    chk({nm, "_timeout"}, int'(done_cnt == 0), 0);
    chk({nm, "_busy_at_done"}, int'(busy), 0);
  endtask

  task automatic run_job(input vec_t v, input string nm);
    start_job(v);
    wait_done(nm);
    chk({nm, "_writes"}, wr_cnt, v.exp_wr);
    chk({nm, "_reads"}, rd_cnt, v.exp_rd);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vec_t z;
    int c;
    //          sw sh dw dh  stx     sty     sbase  dbase  img st  wr  rd
    vecs[0] = '{2, 2, 4, 4, 'h0080, 'h0080, 'h100, 'h800, 0, 0, 16, 64};
    vecs[1] = '{2, 2, 1, 1, 'h0040, 'h0040, 'h200, 'h900, 1, 0,  1,  4};
    vecs[2] = '{2, 2, 2, 1, 'h0040, 'h0040, 'h200, 'h900, 1, 0,  2,  8};
    vecs[3] = '{8, 3, 6, 2, 'h0100, 'h0100, 'h300, 'hA00, 2, 0, 12, 48};
    vecs[4] = '{2, 2, 4, 4, 'h0080, 'h0080, 'h100, 'h800, 0, 1, 16, 64};
    vecs[5] = '{9, 7, 5, 3, 'h01C0, 'h0200, 'h400, 'hB00, 2, 1, 15, 60};
    vecs[6] = '{8, 3, 6, 2, 'h0100, 'h0100, 'h300, 'hA00, 2, 1, 12, 48};

    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_outs", int'({job_done, rd_req, dp_start, wr_en}), 0);
    chk("rst_ops", int'(dp_p00 | dp_p11), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_job(vecs[i], $sformatf("job%0d", i));
      if (i == 0 || i == 4) begin
        chk("t1_out00", int'(out_mem['h800]), 100);
        chk("t1_out11", int'(out_mem['h805]), 130);
        chk("t1_out33", int'(out_mem['h80F]), 160);
      end
      if (i == 1) chk("t2_out00", int'(out_mem['h900]), 50);
      if (i == 2) chk("t2_out10", int'(out_mem['h901]), 75);
    end

    // Reset in the middle of FETCH aborts without job_done and clears outputs/operands.
    start_job(vecs[0]);
    c = 0;
    while (rd_cnt < 7 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("t5_reach_fetch", int'(rd_cnt >= 7), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", int'(busy), 0);
    chk("t5_ctl", int'({job_done, rd_req, dp_start, wr_en}), 0);
    chk("t5_addr", int'(rd_addr | wr_addr), 0);
    chk("t5_ops", int'(dp_p00 | dp_p01 | dp_p10 | dp_p11), 0);
    chk("t5_frac", int'(|{dp_a, dp_b}), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("t5_no_done", done_cnt, 0);
    run_job(vecs[0], "t5_rerun");
    chk("t5_out11", int'(out_mem['h805]), 130);
    chk("t5_out33", int'(out_mem['h80F]), 160);

    // Zero-height job: done two cycles after start, no traffic.
    z = '{2, 2, 4, 0, 'h0080, 'h0080, 'h100, 'hC00, 0, 0, 0, 0};
    start_job(z);
    chk("t6_busy_c1", int'({busy, job_done}), 2);
    @(negedge clk);
    chk("t6_done_c2", int'({busy, job_done}), 1);
    repeat (10) @(negedge clk);
    chk("t6_traffic", rd_cnt + wr_cnt, 0);
    chk("t6_done_cnt", done_cnt, 1);

    // job_start while busy is ignored.
    start_job(vecs[1]);
    cfg_dst_w = 10'd4; cfg_dst_h = 10'd4; cfg_dst_base = 20'hD00;
    job_start = 1'b1;
    @(negedge clk);
    job_start = 1'b0;
    wait_done("t6_busy_job");
    repeat (20) @(negedge clk);
    chk("t6_ign_writes", wr_cnt, 1);
    chk("t6_ign_reads", rd_cnt, 4);
    chk("t6_ign_done", done_cnt, 1);
    chk("t6_ign_out", int'(out_mem['h900]), 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
